// File: rtl/branch_prediction_unit.sv
// Gshare direction predictor with a tagged direct-mapped BTB and a speculative GHR
// that is repaired from EX on mispredict. Optional perf counters: BPU_PERF_CNT_EN.
module branch_prediction_unit #(
  parameter int PC_W      = 32,
  parameter int BTB_DEPTH = 64,
  parameter int TAG_W     = 8,
  parameter int GHR_W     = 8
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             stall_fi_i,
  input  logic             stall_ex_i,
  input  logic             flush_ex_i,
  input  logic [PC_W-1:0]  pc_fi_i,
  input  logic [PC_W-1:0]  pc_ex_i,
  input  logic [PC_W-1:0]  pc_target_ex_i,
  input  logic [1:0]       branch_op_ex_i,
  input  logic             pc_src_res_ex_i,
  input  logic             pc_src_pred_ex_i,
  input  logic             target_match_ex_i,
  input  logic [GHR_W-1:0] ghr_ex_i,
  output logic             pc_src_pred_fi_o,
  output logic [PC_W-1:0]  pred_pc_target_fi_o,
  output logic [GHR_W-1:0] ghr_fi_o,
  output logic             mispredict_ex_o,
  output logic [31:0]      br_cnt_o,
  output logic [31:0]      mispred_cnt_o
);
  localparam int BIDX_W = $clog2(BTB_DEPTH);
  localparam int PHT_N  = 1 << GHR_W;
  localparam int TAG_LO = BIDX_W + 2;
  localparam int TAG_HI = BIDX_W + TAG_W + 1;

  logic [BTB_DEPTH-1:0] btb_valid_q, btb_valid_d;
  logic [BTB_DEPTH-1:0] btb_cond_q, btb_cond_d;
  logic [TAG_W-1:0]     btb_tag_q [BTB_DEPTH];
  logic [TAG_W-1:0]     btb_tag_d [BTB_DEPTH];
  logic [PC_W-1:0]      btb_tgt_q [BTB_DEPTH];
  logic [PC_W-1:0]      btb_tgt_d [BTB_DEPTH];
  logic [1:0]           pht_q [PHT_N];
  logic [1:0]           pht_d [PHT_N];
  logic [GHR_W-1:0]     ghr_q, ghr_d;

  logic [BIDX_W-1:0] bidx_fi, bidx_ex;
  logic [TAG_W-1:0]  tag_fi, tag_ex;
  logic [GHR_W-1:0]  pidx_fi, pidx_ex;
  logic              hit_fi, cond_fi, upd, is_cond_op;

  assign bidx_fi = pc_fi_i[BIDX_W+1:2];
  assign tag_fi  = pc_fi_i[TAG_HI:TAG_LO];
  assign pidx_fi = pc_fi_i[GHR_W+1:2] ^ ghr_q;
  assign bidx_ex = pc_ex_i[BIDX_W+1:2];
  assign tag_ex  = pc_ex_i[TAG_HI:TAG_LO];
  assign pidx_ex = pc_ex_i[GHR_W+1:2] ^ ghr_ex_i;

  // Fetch lookup reads only registered state, so an EX write this cycle is not seen.
  assign hit_fi              = btb_valid_q[bidx_fi] && (btb_tag_q[bidx_fi] == tag_fi);
  assign cond_fi             = btb_cond_q[bidx_fi];
  assign pc_src_pred_fi_o    = hit_fi & (~cond_fi | pht_q[pidx_fi][1]);
  assign pred_pc_target_fi_o = hit_fi ? btb_tgt_q[bidx_fi] : '0;
  assign ghr_fi_o            = ghr_q;

  assign is_cond_op      = (branch_op_ex_i == 2'b01);
  assign upd             = (branch_op_ex_i != 2'b00) & ~stall_ex_i & ~flush_ex_i;
  assign mispredict_ex_o = upd & ((pc_src_res_ex_i != pc_src_pred_ex_i) |
                                  (pc_src_res_ex_i & ~target_match_ex_i));

  always_comb begin
    btb_valid_d = btb_valid_q;
    btb_cond_d  = btb_cond_q;
    btb_tag_d   = btb_tag_q;
    btb_tgt_d   = btb_tgt_q;
    pht_d       = pht_q;
    ghr_d       = ghr_q;
    if (upd && is_cond_op) begin
      if (pc_src_res_ex_i) begin
        if (pht_q[pidx_ex] != 2'b11) pht_d[pidx_ex] = pht_q[pidx_ex] + 2'd1;
      end else begin
        if (pht_q[pidx_ex] != 2'b00) pht_d[pidx_ex] = pht_q[pidx_ex] - 2'd1;
      end
    end
    if (upd && pc_src_res_ex_i) begin
      btb_valid_d[bidx_ex] = 1'b1;
      btb_cond_d[bidx_ex]  = is_cond_op;
      btb_tag_d[bidx_ex]   = tag_ex;
      btb_tgt_d[bidx_ex]   = pc_target_ex_i;
    end
    // Repair from the EX snapshot takes priority over the speculative shift.
    if (mispredict_ex_o) begin
      ghr_d = is_cond_op ? {ghr_ex_i[GHR_W-2:0], pc_src_res_ex_i} : ghr_ex_i;
    end else if (hit_fi && cond_fi && !stall_fi_i) begin
      ghr_d = {ghr_q[GHR_W-2:0], pc_src_pred_fi_o};
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      btb_valid_q <= '0;
      btb_cond_q  <= '0;
      ghr_q       <= '0;
      for (int i = 0; i < BTB_DEPTH; i++) begin
        btb_tag_q[i] <= '0;
        btb_tgt_q[i] <= '0;
      end
      for (int i = 0; i < PHT_N; i++) pht_q[i] <= 2'b01;
    end else begin
      btb_valid_q <= btb_valid_d;
      btb_cond_q  <= btb_cond_d;
      btb_tag_q   <= btb_tag_d;
      btb_tgt_q   <= btb_tgt_d;
      pht_q       <= pht_d;
      ghr_q       <= ghr_d;
    end
  end

`ifdef BPU_PERF_CNT_EN
  logic [31:0] br_cnt_q, br_cnt_d, mispred_cnt_q, mispred_cnt_d;

  always_comb begin
    br_cnt_d      = br_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (upd && br_cnt_q != 32'hFFFF_FFFF) br_cnt_d = br_cnt_q + 32'd1;
    if (mispredict_ex_o && mispred_cnt_q != 32'hFFFF_FFFF) mispred_cnt_d = mispred_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      br_cnt_q      <= '0;
      mispred_cnt_q <= '0;
    end else begin
      br_cnt_q      <= br_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign br_cnt_o      = br_cnt_q;
  assign mispred_cnt_o = mispred_cnt_q;
`else
  assign br_cnt_o      = '0;
  assign mispred_cnt_o = '0;
`endif

  // PC bits outside the index/tag fields do not take part in prediction.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc_fi_i[PC_W-1:TAG_HI+1], pc_fi_i[1:0],
                            pc_ex_i[PC_W-1:TAG_HI+1], pc_ex_i[1:0]};
endmodule

// File: tb/tb_branch_prediction_unit.sv
// Bench for branch_prediction_unit: behavioural table model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_branch_prediction_unit;
  logic        clk_i = 1'b0;
  logic        reset_ni;
  logic        stall_fi_i, stall_ex_i, flush_ex_i;
  logic [31:0] pc_fi_i, pc_ex_i, pc_target_ex_i;
  logic [1:0]  branch_op_ex_i;
  logic        pc_src_res_ex_i, pc_src_pred_ex_i, target_match_ex_i;
  logic [7:0]  ghr_ex_i;
  logic        pc_src_pred_fi_o;
  logic [31:0] pred_pc_target_fi_o;
  logic [7:0]  ghr_fi_o;
  logic        mispredict_ex_o;
  logic [31:0] br_cnt_o, mispred_cnt_o;

  int tests_run = 0;
  int tests_failed = 0;

  branch_prediction_unit dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .stall_fi_i(stall_fi_i), .stall_ex_i(stall_ex_i),
    .flush_ex_i(flush_ex_i), .pc_fi_i(pc_fi_i), .pc_ex_i(pc_ex_i),
    .pc_target_ex_i(pc_target_ex_i), .branch_op_ex_i(branch_op_ex_i),
    .pc_src_res_ex_i(pc_src_res_ex_i), .pc_src_pred_ex_i(pc_src_pred_ex_i),
    .target_match_ex_i(target_match_ex_i), .ghr_ex_i(ghr_ex_i),
    .pc_src_pred_fi_o(pc_src_pred_fi_o), .pred_pc_target_fi_o(pred_pc_target_fi_o),
    .ghr_fi_o(ghr_fi_o), .mispredict_ex_o(mispredict_ex_o),
    .br_cnt_o(br_cnt_o), .mispred_cnt_o(mispred_cnt_o)
  );

  // ---------------- clock ----------------
  always #5 clk_i = ~clk_i;

  // ---------------- behavioural model ----------------
  int          m_pht [256];
  bit          m_v   [64];
  bit          m_c   [64];
  int          m_tag [64];
  logic [31:0] m_tgt [64];
  int          m_ghr;
  longint      m_br, m_mis;

  function automatic void model_reset();
    for (int i = 0; i < 256; i++) m_pht[i] = 1;
    for (int i = 0; i < 64; i++) begin
      m_v[i] = 0; m_c[i] = 0; m_tag[i] = 0; m_tgt[i] = 0;
    end
    m_ghr = 0; m_br = 0; m_mis = 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // One compare process: check against the model, then advance the model for the next edge.
  always @(negedge clk_i) begin
    int bi, tg, pi, bi_e, tg_e, pi_e, next_ghr;
    bit hit, pred, upd, mis;
    logic [31:0] tgt, exp_br, exp_mis;
    if (!reset_ni) model_reset();
    bi  = int'((pc_fi_i >> 2) & 32'd63);
    tg  = int'((pc_fi_i >> 8) & 32'd255);
    pi  = int'((pc_fi_i >> 2) & 32'd255) ^ m_ghr;
    hit = m_v[bi] && m_tag[bi] == tg;
    pred = hit && (!m_c[bi] || m_pht[pi] >= 2);
    tgt = hit ? m_tgt[bi] : 32'd0;
    upd = branch_op_ex_i != 2'd0 && !stall_ex_i && !flush_ex_i;
    mis = upd && (pc_src_res_ex_i != pc_src_pred_ex_i || (pc_src_res_ex_i && !target_match_ex_i));
`ifdef BPU_PERF_CNT_EN
    exp_br = m_br[31:0]; exp_mis = m_mis[31:0];
`else
    exp_br = 32'd0; exp_mis = 32'd0;
`endif
    chk("pred_fi", {31'd0, pc_src_pred_fi_o}, {31'd0, pred});
    chk("target_fi", pred_pc_target_fi_o, tgt);
    chk("ghr_fi", {24'd0, ghr_fi_o}, m_ghr);
    chk("mispredict", {31'd0, mispredict_ex_o}, {31'd0, mis});
    chk("br_cnt", br_cnt_o, exp_br);
    chk("mispred_cnt", mispred_cnt_o, exp_mis);
    if (reset_ni) begin
      bi_e = int'((pc_ex_i >> 2) & 32'd63);
      tg_e = int'((pc_ex_i >> 8) & 32'd255);
      pi_e = int'((pc_ex_i >> 2) & 32'd255) ^ int'(ghr_ex_i);
      next_ghr = m_ghr;
      if (mis) begin
        if (branch_op_ex_i == 2'd1) next_ghr = ((int'(ghr_ex_i) * 2) + int'(pc_src_res_ex_i)) % 256;
        else next_ghr = int'(ghr_ex_i);
      end else if (hit && m_c[bi] && !stall_fi_i) begin
        next_ghr = ((m_ghr * 2) + int'(pred)) % 256;
      end
      if (upd && branch_op_ex_i == 2'd1) begin
        if (pc_src_res_ex_i) m_pht[pi_e] = (m_pht[pi_e] < 3) ? m_pht[pi_e] + 1 : 3;
        else m_pht[pi_e] = (m_pht[pi_e] > 0) ? m_pht[pi_e] - 1 : 0;
      end
      if (upd && pc_src_res_ex_i) begin
        m_v[bi_e] = 1; m_tag[bi_e] = tg_e; m_tgt[bi_e] = pc_target_ex_i;
        m_c[bi_e] = (branch_op_ex_i == 2'd1);
      end
      m_ghr = next_ghr;
      if (upd && m_br < 64'hFFFF_FFFF) m_br++;
      if (mis && m_mis < 64'hFFFF_FFFF) m_mis++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk_i); #1;
  endtask

  task automatic set_ex(input logic [1:0] op, input logic [31:0] pc, input logic [31:0] tgt,
                        input logic res, input logic pred, input logic tm, input logic [7:0] g);
    branch_op_ex_i = op; pc_ex_i = pc; pc_target_ex_i = tgt; pc_src_res_ex_i = res;
    pc_src_pred_ex_i = pred; target_match_ex_i = tm; ghr_ex_i = g;
  endtask

  task automatic idle_ex();
    set_ex(2'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    stall_ex_i = 1'b0; flush_ex_i = 1'b0;
  endtask

  logic [31:0] pc_pool [8];
  logic [31:0] exp_br10, exp_mis3;

  initial begin
    pc_pool[0] = 32'h100; pc_pool[1] = 32'h104; pc_pool[2] = 32'h108; pc_pool[3] = 32'h200;
    pc_pool[4] = 32'h500; pc_pool[5] = 32'h1100; pc_pool[6] = 32'h3F04; pc_pool[7] = 32'h10C;
`ifdef BPU_PERF_CNT_EN
    exp_br10 = 32'd10; exp_mis3 = 32'd3;
`else
    exp_br10 = 32'd0; exp_mis3 = 32'd0;
`endif
    reset_ni = 1'b0; stall_fi_i = 1'b0; pc_fi_i = 32'h100;
    idle_ex();
    repeat (2) @(posedge clk_i);
    #1 reset_ni = 1'b1;

    // Reset state
    cyc(); pc_fi_i = 32'h100; #2;
    chk("t1_pred", {31'd0, pc_src_pred_fi_o}, 32'd0);
    chk("t1_target", pred_pc_target_fi_o, 32'd0);
    chk("t1_ghr", {24'd0, ghr_fi_o}, 32'd0);

    // First taken cond branch, mispredicted
    cyc(); set_ex(2'd1, 32'h100, 32'h180, 1'b1, 1'b0, 1'b0, 8'h00); #2;
    chk("t2_mis", {31'd0, mispredict_ex_o}, 32'd1);
    cyc(); idle_ex(); stall_fi_i = 1'b1; #2;
    chk("t2_target", pred_pc_target_fi_o, 32'h180);
    chk("t2_ghr", {24'd0, ghr_fi_o}, 32'h01);
    chk("t2_pred_ghr1", {31'd0, pc_src_pred_fi_o}, 32'd0);

    // Saturate, then one not-taken still predicts taken
    for (int i = 0; i < 3; i++) begin
      cyc(); set_ex(2'd1, 32'h100, 32'h180, 1'b1, 1'b1, 1'b1, 8'h00); #2;
      chk("t3_nomis", {31'd0, mispredict_ex_o}, 32'd0);
    end
    cyc(); set_ex(2'd1, 32'h100, 32'h180, 1'b0, 1'b1, 1'b1, 8'h00); #2;
    chk("t3_mis_nt", {31'd0, mispredict_ex_o}, 32'd1);
    cyc(); idle_ex(); stall_fi_i = 1'b0; #2;
    chk("t3_pred", {31'd0, pc_src_pred_fi_o}, 32'd1);
    chk("t3_target", pred_pc_target_fi_o, 32'h180);
    chk("t3_ghr", {24'd0, ghr_fi_o}, 32'h00);

    // jal with wrong target
    cyc(); pc_fi_i = 32'h300; set_ex(2'd2, 32'h200, 32'h300, 1'b1, 1'b1, 1'b0, 8'h55); #2;
    chk("t4_mis", {31'd0, mispredict_ex_o}, 32'd1);
    cyc(); idle_ex(); pc_fi_i = 32'h200; #2;
    chk("t4_pred", {31'd0, pc_src_pred_fi_o}, 32'd1);
    chk("t4_target", pred_pc_target_fi_o, 32'h300);
    chk("t4_ghr", {24'd0, ghr_fi_o}, 32'h55);
    cyc(); pc_fi_i = 32'h100; #2;
    chk("t4_evicted", pred_pc_target_fi_o, 32'd0);

    // F shift and EX recovery in the same cycle
    cyc(); pc_fi_i = 32'h300; set_ex(2'd1, 32'h104, 32'h1A0, 1'b1, 1'b1, 1'b1, 8'h55); #2;
    chk("t5_nomis", {31'd0, mispredict_ex_o}, 32'd0);
    cyc(); pc_fi_i = 32'h104; set_ex(2'd1, 32'h500, 32'h600, 1'b1, 1'b0, 1'b0, 8'h0F); #2;
    chk("t5_mis", {31'd0, mispredict_ex_o}, 32'd1);
    chk("t5_pred", {31'd0, pc_src_pred_fi_o}, 32'd1);
    chk("t5_target", pred_pc_target_fi_o, 32'h1A0);
    cyc(); idle_ex(); stall_fi_i = 1'b1; #2;
    chk("t5_ghr", {24'd0, ghr_fi_o}, 32'h1F);

    // Reset while a training write is pending
    cyc(); stall_fi_i = 1'b0; pc_fi_i = 32'h108;
    set_ex(2'd1, 32'h108, 32'h700, 1'b1, 1'b0, 1'b0, 8'h00);
    #1 reset_ni = 1'b0;
    cyc(); idle_ex(); reset_ni = 1'b1; #2;
    chk("rst_pred", {31'd0, pc_src_pred_fi_o}, 32'd0);
    chk("rst_target", pred_pc_target_fi_o, 32'd0);
    chk("rst_ghr", {24'd0, ghr_fi_o}, 32'd0);

    // Perf counters: 10 branches, 3 mispredicts, stalled/flushed ones ignored
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (i < 3) set_ex(2'd1, 32'h200 + 32'(i * 4), 32'h800, 1'b1, 1'b0, 1'b1, 8'h00);
      else set_ex(2'd2, 32'h200 + 32'(i * 4), 32'h800, 1'b1, 1'b1, 1'b1, 8'h00);
      cyc(); stall_ex_i = 1'b1; set_ex(2'd1, 32'h200, 32'h900, 1'b1, 1'b0, 1'b0, 8'h00);
      cyc(); stall_ex_i = 1'b0; flush_ex_i = 1'b1;
      cyc(); flush_ex_i = 1'b0; idle_ex();
    end
    cyc(); #2;
    chk("t6_br_cnt", br_cnt_o, exp_br10);
    chk("t6_mis_cnt", mispred_cnt_o, exp_mis3);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      cyc();
      pc_fi_i        = ($urandom_range(0, 7) == 0) ? ($urandom & 32'hFFFC) : pc_pool[$urandom_range(0, 7)];
      stall_fi_i     = ($urandom_range(0, 3) == 0);
      branch_op_ex_i = 2'($urandom_range(0, 3));
      pc_ex_i        = pc_pool[$urandom_range(0, 7)];
      pc_target_ex_i = $urandom & 32'hFFFC;
      pc_src_res_ex_i   = 1'($urandom_range(0, 1));
      pc_src_pred_ex_i  = 1'($urandom_range(0, 1));
      target_match_ex_i = ($urandom_range(0, 3) != 0);
      ghr_ex_i       = ($urandom_range(0, 1) == 1) ? 8'(m_ghr) : 8'($urandom_range(0, 255));
      stall_ex_i     = ($urandom_range(0, 7) == 0);
      flush_ex_i     = ($urandom_range(0, 7) == 0);
    end
    cyc(); idle_ex();
    cyc(); #2;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
